regfile_2w_clr: RTL and testbench

//   Parametrised register file: two synchronous write ports, two async read ports, optional

---
 rtl/regfile_2w_clr.sv | 133 +++++++++++++
 tb/tb_regfile_2w_clr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w_clr.sv
// Purpose : register file with two write ports, two read ports and a clear engine (1 entry/cycle).
// Latency : reads are combinational (0 cycles); writes are visible from storage on the next cycle.
// Backpr. : none; while busy the file ignores user writes and returns 0 on both read ports.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   clr_req            request a full clear; only honoured when idle
//   busy               high while the clear engine is running
//   we0/wa0/wd0        write port 0
//   we1/wa1/wd1        write port 1 (wins over port 0 on the same address)
//   ra1/rd1, ra2/rd2   asynchronous read ports
//   wr_collide         registered flag: both ports wrote the same address last idle cycle
module regfile_2w_clr #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   input  logic              we0,
   input  logic [AWIDTH-1:0] wa0,
   input  logic [DWIDTH-1:0] wd0,
   input  logic              we1,
   input  logic [AWIDTH-1:0] wa1,
   input  logic [DWIDTH-1:0] wd1,
   input  logic [AWIDTH-1:0] ra1,
   input  logic [AWIDTH-1:0] ra2,
   output logic [DWIDTH-1:0] rd1,
   output logic [DWIDTH-1:0] rd2,
   output logic              wr_collide
);

   localparam int DEPTH = 1 << AWIDTH;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_CLEAR = 1'b1;

   localparam logic [AWIDTH:0] CNT_LAST = (AWIDTH+1)'(DEPTH - 1);

   logic              state_q, state_d;
   logic [AWIDTH:0]   clr_cnt_q, clr_cnt_d;
   logic              wr_collide_q, wr_collide_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic idle;
   logic same_addr;
   logic wr0_en;
   logic wr1_en;

   // Effective write enables: only when idle, never into a hardwired zero
   // register, and port 0 yields to port 1 on an address match.
   always_comb begin
      idle      = (state_q == ST_IDLE);
      same_addr = (wa0 == wa1);
      wr0_en    = idle && we0 && !((ZERO_REG != 0) && (wa0 == '0)) && !(we1 && same_addr);
      wr1_en    = idle && we1 && !((ZERO_REG != 0) && (wa1 == '0));
   end

   // Clear engine sequencing.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + (AWIDTH+1)'(1);
            end
         end
         default: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
      endcase
      // Raw request collision, counted even when the write itself is dropped
      // because it targets the hardwired zero register.
      wr_collide_d = idle && we0 && we1 && same_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         clr_cnt_q    <= '0;
         wr_collide_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         wr_collide_q <= wr_collide_d;
      end
   end

   // Storage has no reset; the clear engine defines its contents.
   always_ff @(posedge clk) begin
      if (!idle) begin
         mem_q[clr_cnt_q[AWIDTH-1:0]] <= '0;
      end else begin
         if (wr0_en) mem_q[wa0] <= wd0;
         if (wr1_en) mem_q[wa1] <= wd1;
      end
   end

   // Read port 1. Bypass uses the effective enables so dropped writes to
   // register 0 never leak onto the read data.
   always_comb begin
      rd1 = mem_q[ra1];
      if (BYPASS != 0) begin
         if (wr1_en && (wa1 == ra1))      rd1 = wd1;
         else if (wr0_en && (wa0 == ra1)) rd1 = wd0;
      end
      if (!idle || ((ZERO_REG != 0) && (ra1 == '0))) rd1 = '0;
   end

   // Read port 2, identical selection to port 1.
   always_comb begin
      rd2 = mem_q[ra2];
      if (BYPASS != 0) begin
         if (wr1_en && (wa1 == ra2))      rd2 = wd1;
         else if (wr0_en && (wa0 == ra2)) rd2 = wd0;
      end
      if (!idle || ((ZERO_REG != 0) && (ra2 == '0))) rd2 = '0;
   end

   assign busy       = !idle;
   assign wr_collide = wr_collide_q;

endmodule

// File: tb/tb_regfile_2w_clr.sv
module tb_regfile_2w_clr;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic        busy;
   logic        we0, we1;
   logic [4:0]  wa0, wa1, ra1, ra2;
   logic [31:0] wd0, wd1, rd1, rd2;
   logic        wr_collide;

   int errors = 0;
   int checks = 0;

   regfile_2w_clr #(.DWIDTH(32), .AWIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .wr_collide(wr_collide)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr_req = 0; we0 = 0; we1 = 0;
      wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
   endtask

   // Counts cycles spent busy (bounded), driving user writes that must be
   // ignored and flagging any nonzero read data seen meanwhile.
   task automatic run_busy(output int n, output bit rd_bad);
      n = 0;
      rd_bad = 0;
      while (busy && n < 200) begin
         ra1 = 5'(n);
         ra2 = 5'(31 - n);
         we0 = 1; wa0 = 5'd9;  wd0 = 32'h5555_5555;
         we1 = 1; wa1 = 5'd17; wd1 = 32'h6666_6666;
         #1;
         if (rd1 !== 32'h0 || rd2 !== 32'h0) rd_bad = 1;
         step();
         n++;
      end
      idle_inputs();
   endtask

   // Scans every address on both ports; returns count of nonzero reads.
   task automatic scan_zero(output int bad);
      bad = 0;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(a);
         #1;
         if (rd1 !== 32'h0 || rd2 !== 32'h0) bad++;
      end
   endtask

   task automatic test_reset();
      int n;
      bit rd_bad;
      int bad;
      idle_inputs();
      ra1 = 0; ra2 = 0;
      rst = 1;
      #2;
      checks++;
      if (busy !== 1'b1 || rd1 !== 32'h0 || rd2 !== 32'h0 || wr_collide !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b rd1=%h rd2=%h wr_collide=%b, need 1/0/0/0",
                  busy, rd1, rd2, wr_collide);
      end
      step(); step(); step();
      rst = 0;
      run_busy(n, rd_bad);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL reset_busy_cycles: got %0d, need 32", n);
      end
      checks++;
      if (rd_bad) begin
         errors++;
         $display("FAIL reset_reads_while_busy: nonzero read seen, need 0");
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b, need 0", busy);
      end
      scan_zero(bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_contents: %0d nonzero reads, need 0", bad);
      end
   endtask

   task automatic test_bypass();
      we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
      ra1 = 5'd5; ra2 = 5'd6;
      #1;
      checks++;
      if (rd1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle: rd1=%h, need deadbeef", rd1);
      end
      checks++;
      if (rd2 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_other_addr: rd2=%h, need 0", rd2);
      end
      step();
      we0 = 0;
      #1;
      checks++;
      if (rd1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass_storage: rd1=%h, need deadbeef", rd1);
      end
   endtask

   task automatic test_collision();
      we0 = 1; wa0 = 5'd7; wd0 = 32'h1111;
      we1 = 1; wa1 = 5'd7; wd1 = 32'h2222;
      ra1 = 5'd7; ra2 = 5'd7;
      #1;
      checks++;
      if (rd1 !== 32'h2222) begin
         errors++;
         $display("FAIL collide_bypass: rd1=%h, need 2222", rd1);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if (rd2 !== 32'h2222) begin
         errors++;
         $display("FAIL collide_stored: rd2=%h, need 2222", rd2);
      end
      checks++;
      if (wr_collide !== 1'b1) begin
         errors++;
         $display("FAIL collide_pulse: wr_collide=%b, need 1", wr_collide);
      end
      step();
      checks++;
      if (wr_collide !== 1'b0) begin
         errors++;
         $display("FAIL collide_pulse_end: wr_collide=%b, need 0", wr_collide);
      end
      // Distinct addresses on both ports: both stored, no collision.
      we0 = 1; wa0 = 5'd12; wd0 = 32'hA0A0;
      we1 = 1; wa1 = 5'd13; wd1 = 32'hB1B1;
      step();
      idle_inputs();
      ra1 = 5'd12; ra2 = 5'd13;
      #1;
      checks++;
      if (rd1 !== 32'hA0A0 || rd2 !== 32'hB1B1 || wr_collide !== 1'b0) begin
         errors++;
         $display("FAIL dual_write: rd1=%h rd2=%h wr_collide=%b, need a0a0/b1b1/0",
                  rd1, rd2, wr_collide);
      end
   endtask

   task automatic test_zero_reg();
      we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
      ra2 = 5'd0;
      #1;
      checks++;
      if (rd2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_bypass: rd2=%h, need 0", rd2);
      end
      step();
      we1 = 0;
      #1;
      checks++;
      if (rd2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_stored: rd2=%h, need 0", rd2);
      end
      // Dropped writes to reg 0 still count as a collision.
      we0 = 1; wa0 = 5'd0; wd0 = 32'h1;
      we1 = 1; wa1 = 5'd0; wd1 = 32'h2;
      step();
      idle_inputs();
      #1;
      checks++;
      if (wr_collide !== 1'b1 || rd2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_collide: wr_collide=%b rd2=%h, need 1/0", wr_collide, rd2);
      end
   endtask

   task automatic test_clear();
      int n;
      bit rd_bad;
      int bad;
      for (int i = 1; i < 32; i++) begin
         we0 = 1; wa0 = 5'(i); wd0 = 32'(i);
         step();
      end
      idle_inputs();
      ra1 = 5'd10; ra2 = 5'd31;
      #1;
      checks++;
      if (rd1 !== 32'd10 || rd2 !== 32'd31) begin
         errors++;
         $display("FAIL fill: rd1=%h rd2=%h, need a/1f", rd1, rd2);
      end
      // Write in the request cycle commits, then gets cleared.
      clr_req = 1;
      we1 = 1; wa1 = 5'd3; wd1 = 32'hAAAA;
      step();
      idle_inputs();
      run_busy(n, rd_bad);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL clear_busy_cycles: got %0d, need 32", n);
      end
      checks++;
      if (rd_bad) begin
         errors++;
         $display("FAIL clear_reads_while_busy: nonzero read seen, need 0");
      end
      scan_zero(bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL clear_contents: %0d nonzero reads, need 0", bad);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      bit rd_bad;
      int bad;
      for (int i = 1; i < 32; i++) begin
         we0 = 1; wa0 = 5'(i); wd0 = 32'hC000_0000 | 32'(i);
         step();
      end
      idle_inputs();
      clr_req = 1;
      step();
      clr_req = 0;
      for (int i = 0; i < 10; i++) step();
      rst = 1;
      #1;
      checks++;
      if (busy !== 1'b1 || wr_collide !== 1'b0) begin
         errors++;
         $display("FAIL midclear_reset: busy=%b wr_collide=%b, need 1/0", busy, wr_collide);
      end
      step();
      rst = 0;
      run_busy(n, rd_bad);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL midclear_busy_cycles: got %0d, need 32", n);
      end
      checks++;
      if (rd_bad) begin
         errors++;
         $display("FAIL midclear_reads_while_busy: nonzero read seen, need 0");
      end
      scan_zero(bad);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL midclear_contents: %0d nonzero reads, need 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_collision();
      test_zero_reg();
      test_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
